// File: rtl/tmds_encoder_8b10b.sv
// Per-channel TMDS 8b/10b encoder: video, control tokens and (with TMDS_TERC4_EN) TERC4 aux symbols.
// Four register stages from input to dout; one character per pixel clock.
module tmds_encoder_8b10b (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    input  logic       ade,
    input  logic [3:0] aux,
    output logic [9:0] dout
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned QM_W   = 9;
    localparam int unsigned NCNT_W = 4;
    localparam int unsigned DISP_W = 5;
    localparam int unsigned CHAR_W = 10;

    localparam logic [CHAR_W-1:0] CTRL_TOKEN_0 = 10'b1101010100;
    localparam logic [CHAR_W-1:0] CTRL_TOKEN_1 = 10'b0010101011;
    localparam logic [CHAR_W-1:0] CTRL_TOKEN_2 = 10'b0101010100;
    localparam logic [CHAR_W-1:0] CTRL_TOKEN_3 = 10'b1010101011;

    function automatic logic [NCNT_W-1:0] popcount8(input logic [DATA_W-1:0] v);
        logic [NCNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            n = n + NCNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CHAR_W-1:0] ctrl_token(input logic [1:0] c);
        logic [CHAR_W-1:0] t;
        case (c)
            2'b00:   t = CTRL_TOKEN_0;
            2'b01:   t = CTRL_TOKEN_1;
            2'b10:   t = CTRL_TOKEN_2;
            default: t = CTRL_TOKEN_3;
        endcase
        return t;
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [CHAR_W-1:0] terc4_code(input logic [3:0] a);
        logic [CHAR_W-1:0] t;
        case (a)
            4'h0:    t = 10'b1010011100;
            4'h1:    t = 10'b1001100011;
            4'h2:    t = 10'b1011100100;
            4'h3:    t = 10'b1011100010;
            4'h4:    t = 10'b0101110001;
            4'h5:    t = 10'b0100011110;
            4'h6:    t = 10'b0110001110;
            4'h7:    t = 10'b0100111100;
            4'h8:    t = 10'b1011001100;
            4'h9:    t = 10'b0100111001;
            4'hA:    t = 10'b0110011100;
            4'hB:    t = 10'b1011000110;
            4'hC:    t = 10'b1010001110;
            4'hD:    t = 10'b1001110001;
            4'hE:    t = 10'b0101100011;
            default: t = 10'b1011000011;
        endcase
        return t;
    endfunction
`else
    logic unused_aux;
    assign unused_aux = ^{ade, aux};
`endif

    // Input capture
    logic [DATA_W-1:0] in_din;
    logic              in_de;
    logic [1:0]        in_c;

    // Popcount of the captured word
    logic [DATA_W-1:0] s1_din;
    logic [NCNT_W-1:0] s1_n1d;
    logic              s1_de;
    logic [1:0]        s1_c;

    // Transition-minimised word and its ones/zeros counts
    logic [QM_W-1:0]   s2_q_m;
    logic [NCNT_W-1:0] s2_n1q;
    logic [NCNT_W-1:0] s2_n0q;
    logic              s2_de;
    logic [1:0]        s2_c;

`ifdef TMDS_TERC4_EN
    logic       in_ade, s1_ade, s2_ade;
    logic [3:0] in_aux, s1_aux, s2_aux;
`endif

    logic signed [DISP_W-1:0] cnt;

    logic              use_xnor_c;
    logic [QM_W-1:0]   q_m_c;
    logic [NCNT_W-1:0] n1q_c;

    logic [CHAR_W-1:0] dout_next_c;
    logic [DISP_W-1:0] cnt_next_c;
    logic [DISP_W-1:0] diff_c;
    logic              case_a_c;
    logic              case_b_c;

    always_ff @(posedge clkin) begin
        if (rstin) begin
            in_din <= '0;
            in_de  <= 1'b0;
            in_c   <= '0;
            s1_din <= '0;
            s1_n1d <= '0;
            s1_de  <= 1'b0;
            s1_c   <= '0;
            s2_q_m <= '0;
            s2_n1q <= '0;
            s2_n0q <= '0;
            s2_de  <= 1'b0;
            s2_c   <= '0;
`ifdef TMDS_TERC4_EN
            in_ade <= 1'b0;
            s1_ade <= 1'b0;
            s2_ade <= 1'b0;
            in_aux <= '0;
            s1_aux <= '0;
            s2_aux <= '0;
`endif
        end else begin
            in_din <= din;
            in_de  <= de;
            in_c   <= {c1, c0};
            s1_din <= in_din;
            s1_n1d <= popcount8(in_din);
            s1_de  <= in_de;
            s1_c   <= in_c;
            s2_q_m <= q_m_c;
            s2_n1q <= n1q_c;
            s2_n0q <= NCNT_W'(DATA_W) - n1q_c;
            s2_de  <= s1_de;
            s2_c   <= s1_c;
`ifdef TMDS_TERC4_EN
            in_ade <= ade;
            s1_ade <= in_ade;
            s2_ade <= s1_ade;
            in_aux <= aux;
            s1_aux <= in_aux;
            s2_aux <= s1_aux;
`endif
        end
    end

    // XOR/XNOR chaining; q_m[8] records which one was used
    always_comb begin
        use_xnor_c = (s1_n1d > 4'd4) || ((s1_n1d == 4'd4) && !s1_din[0]);
        q_m_c      = '0;
        q_m_c[0]   = s1_din[0];
        for (int i = 1; i < int'(DATA_W); i++) begin
            q_m_c[i] = use_xnor_c ? ~(q_m_c[i-1] ^ s1_din[i]) : (q_m_c[i-1] ^ s1_din[i]);
        end
        q_m_c[8] = ~use_xnor_c;
        n1q_c    = popcount8(q_m_c[7:0]);
    end

    // DC balance against the running disparity; non-video characters reset it
    always_comb begin
        dout_next_c = CTRL_TOKEN_0;
        cnt_next_c  = '0;
        diff_c      = {1'b0, s2_n1q} - {1'b0, s2_n0q};
        case_a_c    = (cnt == 5'sd0) || (s2_n1q == s2_n0q);
        case_b_c    = (!cnt[4] && (s2_n1q > s2_n0q)) || (cnt[4] && (s2_n0q > s2_n1q));

        if (s2_de) begin
            if (case_a_c) begin
                dout_next_c = {~s2_q_m[8], s2_q_m[8], s2_q_m[8] ? s2_q_m[7:0] : ~s2_q_m[7:0]};
                cnt_next_c  = s2_q_m[8] ? (DISP_W'(cnt) + diff_c) : (DISP_W'(cnt) - diff_c);
            end else if (case_b_c) begin
                dout_next_c = {1'b1, s2_q_m[8], ~s2_q_m[7:0]};
                cnt_next_c  = DISP_W'(cnt) + {3'b000, s2_q_m[8], 1'b0} - diff_c;
            end else begin
                dout_next_c = {1'b0, s2_q_m[8], s2_q_m[7:0]};
                cnt_next_c  = DISP_W'(cnt) - {3'b000, ~s2_q_m[8], 1'b0} + diff_c;
            end
        end else begin
            cnt_next_c = '0;
`ifdef TMDS_TERC4_EN
            if (s2_ade) begin
                dout_next_c = terc4_code(s2_aux);
            end else begin
                dout_next_c = ctrl_token(s2_c);
            end
`else
            dout_next_c = ctrl_token(s2_c);
`endif
        end
    end

    always_ff @(posedge clkin) begin
        if (rstin) begin
            dout <= CTRL_TOKEN_0;
            cnt  <= '0;
        end else begin
            dout <= dout_next_c;
            cnt  <= cnt_next_c;
        end
    end

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// Directed-vector bench for tmds_encoder_8b10b; expected characters and disparities hand-computed.
module tb_tmds_encoder_8b10b;

    logic       clkin = 1'b0;
    logic       rstin;
    logic [7:0] din;
    logic       c0, c1, de, ade;
    logic [3:0] aux;
    logic [9:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [9:0] CTRL0   = 10'b1101010100;
    localparam logic [9:0] CTRL1   = 10'b0010101011;
    localparam logic [9:0] CTRL2   = 10'b0101010100;
    localparam logic [9:0] CTRL3   = 10'b1010101011;
    localparam logic [9:0] ENC_A5  = 10'b0101100011;
    localparam logic [9:0] ENC_5A  = 10'b1001100011;
    localparam logic [9:0] Z_A     = 10'b0100000000;
    localparam logic [9:0] Z_B     = 10'b1111111111;
    localparam logic [9:0] F_A     = 10'b1000000000;
    localparam logic [9:0] F_C     = 10'b0011111111;

    tmds_encoder_8b10b dut (
        .clkin (clkin),
        .rstin (rstin),
        .din   (din),
        .c0    (c0),
        .c1    (c1),
        .de    (de),
        .ade   (ade),
        .aux   (aux),
        .dout  (dout)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic flush_ctrl();
        de = 1'b0; ade = 1'b0; c0 = 1'b0; c1 = 1'b0; din = 8'h00;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        rstin = 1'b1; de = 1'b1; din = 8'hA5; c0 = 1'b0; c1 = 1'b0; ade = 1'b0; aux = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (dout !== CTRL0) begin
                n_bad++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, dout, CTRL0);
            end
        end
        n_cmp++;
        if (dut.cnt !== 5'sd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d want 0", dut.cnt);
        end
        rstin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dout !== CTRL0) begin
                n_bad++;
                $display("FAIL reset_flush cyc %0d: got %b want %b", i, dout, CTRL0);
            end
        end
        tick();
        n_cmp++;
        if (dout !== ENC_A5) begin
            n_bad++;
            $display("FAIL reset_first_word: got %b want %b", dout, ENC_A5);
        end
    endtask

    task automatic test_control();
        logic [9:0] tok [4];
        tok[0] = CTRL0; tok[1] = CTRL1; tok[2] = CTRL2; tok[3] = CTRL3;
        de = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) {c1, c0} = 2'(i);
            tick();
            if (i >= 3) begin
                n_cmp++;
                if (dout !== tok[i-3]) begin
                    n_bad++;
                    $display("FAIL control_token c=%0d: got %b want %b", i - 3, dout, tok[i-3]);
                end
            end
        end
        n_cmp++;
        if (dut.cnt !== 5'sd0) begin
            n_bad++;
            $display("FAIL control_cnt: got %0d want 0", dut.cnt);
        end
    endtask

    task automatic test_disparity();
        logic [9:0]        exp_d [3];
        logic signed [4:0] exp_c [3];
        exp_d[0] = Z_A;  exp_d[1] = Z_B;  exp_d[2] = Z_A;
        exp_c[0] = -5'sd8; exp_c[1] = 5'sd2; exp_c[2] = -5'sd6;
        flush_ctrl();
        de = 1'b1; din = 8'h00;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 3) begin
                n_cmp++;
                if (dout !== exp_d[i-3]) begin
                    n_bad++;
                    $display("FAIL disparity_dout w%0d: got %b want %b", i - 3, dout, exp_d[i-3]);
                end
                n_cmp++;
                if (dut.cnt !== exp_c[i-3]) begin
                    n_bad++;
                    $display("FAIL disparity_cnt w%0d: got %0d want %0d", i - 3, dut.cnt, exp_c[i-3]);
                end
            end
        end
    endtask

    task automatic test_xnor();
        logic [9:0]        exp_d [3];
        logic signed [4:0] exp_c [3];
        exp_d[0] = F_A;  exp_d[1] = F_C;  exp_d[2] = F_C;
        exp_c[0] = -5'sd8; exp_c[1] = -5'sd2; exp_c[2] = 5'sd4;
        flush_ctrl();
        de = 1'b1; din = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 3) begin
                n_cmp++;
                if (dout !== exp_d[i-3]) begin
                    n_bad++;
                    $display("FAIL xnor_dout w%0d: got %b want %b", i - 3, dout, exp_d[i-3]);
                end
                n_cmp++;
                if (dut.cnt !== exp_c[i-3]) begin
                    n_bad++;
                    $display("FAIL xnor_cnt w%0d: got %0d want %0d", i - 3, dut.cnt, exp_c[i-3]);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [7:0]        vec   [3];
        logic [9:0]        exp_d [3];
        logic signed [4:0] exp_c [3];
        vec[0] = 8'h5A; vec[1] = 8'hA5; vec[2] = 8'h00;
        exp_d[0] = ENC_5A; exp_d[1] = ENC_A5; exp_d[2] = Z_A;
        exp_c[0] = 5'sd0; exp_c[1] = 5'sd0; exp_c[2] = -5'sd8;
        flush_ctrl();
        de = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = (i < 3) ? vec[i] : 8'h00;
            tick();
            if (i >= 3) begin
                n_cmp++;
                if (dout !== exp_d[i-3]) begin
                    n_bad++;
                    $display("FAIL boundary_dout w%0d: got %b want %b", i - 3, dout, exp_d[i-3]);
                end
                n_cmp++;
                if (dut.cnt !== exp_c[i-3]) begin
                    n_bad++;
                    $display("FAIL boundary_cnt w%0d: got %0d want %0d", i - 3, dut.cnt, exp_c[i-3]);
                end
            end
        end
    endtask

    task automatic test_de_transition();
        flush_ctrl();
        c0 = 1'b0; c1 = 1'b0; din = 8'h00;
        for (int i = 0; i < 21; i++) begin
            de = (i != 16);
            tick();
            if (i == 18) begin
                n_cmp++;
                if (dout !== Z_A || dut.cnt !== -5'sd2) begin
                    n_bad++;
                    $display("FAIL de_last_video: got %b/%0d want %b/-2", dout, dut.cnt, Z_A);
                end
            end else if (i == 19) begin
                n_cmp++;
                if (dout !== CTRL0 || dut.cnt !== 5'sd0) begin
                    n_bad++;
                    $display("FAIL de_ctrl_clear: got %b/%0d want %b/0", dout, dut.cnt, CTRL0);
                end
            end else if (i == 20) begin
                n_cmp++;
                if (dout !== Z_A || dut.cnt !== -5'sd8) begin
                    n_bad++;
                    $display("FAIL de_first_video: got %b/%0d want %b/-8", dout, dut.cnt, Z_A);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        flush_ctrl();
        de = 1'b1; din = 8'hFF;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (dut.cnt !== 5'sd4) begin
            n_bad++;
            $display("FAIL midrst_pre_cnt: got %0d want 4", dut.cnt);
        end
        rstin = 1'b1; din = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (dout !== CTRL0 || dut.cnt !== 5'sd0) begin
                n_bad++;
                $display("FAIL midrst_hold cyc %0d: got %b/%0d want %b/0", i, dout, dut.cnt, CTRL0);
            end
        end
        rstin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dout !== CTRL0) begin
                n_bad++;
                $display("FAIL midrst_flush cyc %0d: got %b want %b", i, dout, CTRL0);
            end
        end
        tick();
        n_cmp++;
        if (dout !== Z_A || dut.cnt !== -5'sd8) begin
            n_bad++;
            $display("FAIL midrst_first_word: got %b/%0d want %b/-8", dout, dut.cnt, Z_A);
        end
    endtask

    task automatic test_aux();
        logic [9:0] exp_d [2];
`ifdef TMDS_TERC4_EN
        exp_d[0] = 10'b1010011100; exp_d[1] = 10'b1011000011;
`else
        exp_d[0] = CTRL0; exp_d[1] = CTRL0;
`endif
        flush_ctrl();
        ade = 1'b1;
        for (int i = 0; i < 5; i++) begin
            aux = (i == 0) ? 4'h0 : 4'hF;
            tick();
            if (i >= 3) begin
                n_cmp++;
                if (dout !== exp_d[i-3] || dut.cnt !== 5'sd0) begin
                    n_bad++;
                    $display("FAIL aux_symbol %0d: got %b/%0d want %b/0", i - 3, dout, dut.cnt, exp_d[i-3]);
                end
            end
        end
        ade = 1'b0;
    endtask

    initial begin
        test_reset();
        test_control();
        test_disparity();
        test_xnor();
        test_boundary();
        test_de_transition();
        test_reset_midstream();
        test_aux();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_8b10b.md
# tmds_encoder_8b10b

Per-channel TMDS encoder converting one 8-bit pixel component, or one control/auxiliary symbol, into a 10-bit DC-balanced TMDS character each pixel clock. Three instances (B/G/R) sit in the HDMI transmit path between the video timing/pattern source and the 10:1 DDR serializers. Each serializer consumes `dout` and transmits bit 0 first. The block is fully pipelined, with a fixed latency and one character output per clock.

## Interface
- No parameters.
- `clkin`  in  1  pixel clock; all logic on rising edge.
- `rstin`  in  1  reset, synchronous and active-high.
- `din`  in  8  pixel component, valid when `de`=1.
- `c0`, `c1`  in  1 each  control bits (HSYNC/VSYNC on the blue channel, otherwise 0); used when `de`=0 and no aux symbol is selected.
- `de`  in  1  video data enable.
- `ade`  in  1  auxiliary data enable. Only active with `TMDS_TERC4_EN`.
- `aux`  in  4  TERC4 nibble, used when `ade`=1 and `de`=0.
- `dout`  out  10  encoded TMDS character.

## Operation
- Input priority: `de`=1 selects video encoding; otherwise `ade`=1 selects TERC4 (macro builds only); otherwise a control token is sent.
- Stage 1:
  - Register `din`, `de`, `ade`, `aux`, `c1:c0`.
  - Compute `n1d` = popcount(`din`), 4 bits.
- Stage 2, transition minimisation:
  - If `n1d`>4, or `n1d`==4 and `din[0]`==0, use XNOR chaining; otherwise XOR chaining.
  - Chaining: `q_m[0]`=`din[0]`; `q_m[i]`=`q_m[i-1]` op `din[i]` for i=1..7.
  - `q_m[8]`=1 for XOR, 0 for XNOR.
  - Register `q_m[8:0]`, `n1q`=popcount(`q_m[7:0]`), `n0q`=8−`n1q`, and the delayed controls.
- Stage 3, DC balance. `cnt` is a signed 5-bit running disparity.
  - Case A, `cnt`==0 or `n1q`==`n0q`:
    - `dout` = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - `cnt` += q_m[8] ? (`n1q`−`n0q`) : (`n0q`−`n1q`).
  - Case B, (`cnt`>0 and `n1q`>`n0q`) or (`cnt`<0 and `n0q`>`n1q`):
    - `dout` = {1, q_m[8], ~q_m[7:0]}.
    - `cnt` += 2·q_m[8] + (`n0q`−`n1q`).
  - Case C, otherwise:
    - `dout` = {0, q_m[8], q_m[7:0]}.
    - `cnt` += −2·(~q_m[8]) + (`n1q`−`n0q`).
- Non-video character (stage-3 `de`=0):
  - `cnt` is forced to 0.
  - Control token by {c1,c0}: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- All arithmetic is signed 5-bit with sign extension of the 4-bit counts. `cnt` never overflows for any legal input sequence.

## Timing
- Latency: inputs sampled at edge N appear on `dout` after edge N+3. Throughput is 1 character per clock.
- No handshake. The input is a continuous stream and every cycle produces a character.
- Reset values:
  - `dout`=1101010100 (control token 00).
  - `cnt`=0.
  - All pipeline registers are cleared, so the delayed `de`=0 and `ade`=0 and {c1,c0}=00.
- Reset asserted mid-stream: `dout`=1101010100 from the first edge with `rstin`=1 and throughout reset.
  - After release, 3 more cycles of token 00 while the cleared pipeline flushes.
  - The first post-reset input appears at N+3.
- `de` 0→1: the first video character is encoded with `cnt`=0.
- `de` 1→0: `cnt` clears on the first control character.

## Configuration
- Macro: `TMDS_TERC4_EN`.
- Defined: when stage-3 `ade`=1 and `de`=0, `dout` = TERC4(`aux`) and `cnt` is forced to 0. Table `aux`→`dout`:
  - 0→1010011100, 1→1001100011, 2→1011100100, 3→1011100010
  - 4→0101110001, 5→0100011110, 6→0110001110, 7→0100111100
  - 8→1011001100, 9→0100111001, A→0110011100, B→1011000110
  - C→1010001110, D→1001110001, E→0101100011, F→1011000011
- Undefined: `ade` and `aux` are ignored (no TERC4 logic or pipeline registers). Every non-video cycle emits a control token (DVI-only encoder).

## Test plan
- Reset: hold `rstin`=1 for 4 clocks with `de`=1, `din`=0xA5 → `dout`=1101010100 every cycle of reset and for 3 cycles after release; the 4th post-release cycle carries encoded 0xA5.
- Control tokens: `de`=0, {c1,c0} stepped 00,01,10,11 on consecutive clocks → `dout` 1101010100, 0010101011, 0101010100, 1010101011, starting 3 clocks later.
- Disparity: from `cnt`=0, apply `de`=1 with `din`=0x00 for 3 clocks:
  - `dout` = 0100000000, 1111111111, 0100000000.
  - `cnt` = −8, +2, −6.
- De transition: 16 video words then `de`=0 for 1 clock then video again → `cnt` reads 0 after the control character; the first new video word is encoded as Case A.
- Random soak: 100k cycles of random `din`/`de` against a bit-exact reference model → zero mismatches; `cnt` never wraps; decoding every video `dout` recovers `din`.
- TERC4 (macro defined): `de`=0, `ade`=1, `aux`=0x0 then 0xF → `dout` 1010011100, 1011000011. With the macro undefined, the same stimulus with {c1,c0}=00 → 1101010100.
